// File: rtl/alu_result_checker_if.sv
// Transaction bus between the ALU stimulus/observation side and the result
// checker: one handshake plus the opcode, operands and the observed result.
interface alu_result_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] dut_s;
  logic       dut_cout;

  // Source side: presents transactions, watches in_ready.
  modport master (
    output in_valid, op, a, b, dut_s, dut_cout,
    input  in_ready
  );

  // Checker side: consumes transactions, drives in_ready.
  modport slave (
    input  in_valid, op, a, b, dut_s, dut_cout,
    output in_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// Self-checking receiver for the 8-bit ALU result stream. Stage 1 registers
// each accepted transaction together with its golden {cout,s}; stage 2
// compares and updates the saturating counters, the first-failure capture
// and a 16-bit MISR over the observed results. Optionally halts on the
// first mismatch.
module alu_result_checker #(
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  alu_result_checker_if.slave txn,
  output logic [CNT_W-1:0]  checked_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  illegal_cnt,
  output logic              fail,
  output logic [3:0]        ff_op,
  output logic [7:0]        ff_a,
  output logic [7:0]        ff_b,
  output logic [8:0]        ff_exp,
  output logic [8:0]        ff_got,
  output logic [15:0]       signature,
  output logic              halted
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_NOT  = 4'b1100;
  localparam logic [3:0] OP_INC  = 4'b1101;

  localparam logic [15:0]      SIG_SEED = 16'hFFFF;
  localparam logic [15:0]      SIG_POLY = 16'h1021;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  state_e     state;
  logic       ready_q;

  // Stage-1 transaction register
  logic       s1_valid;
  logic [3:0] s1_op;
  logic [7:0] s1_a;
  logic [7:0] s1_b;
  logic [8:0] s1_exp;
  logic [8:0] s1_got;
  logic       s1_illegal;

  // Golden model outputs for the transaction currently on the bus
  logic [8:0] gold;
  logic       gold_illegal;

  logic        accept;
  logic        cmp_en;
  logic        mismatch;
  logic [15:0] sig_next;

  assign txn.in_ready = ready_q;
  assign accept       = txn.in_valid & ready_q;
  assign cmp_en       = s1_valid & (state == ST_RUN);
  assign mismatch     = cmp_en & (s1_exp != s1_got);
  assign sig_next     = {signature[14:0], 1'b0}
                      ^ (signature[15] ? SIG_POLY : 16'h0000)
                      ^ {7'b0, s1_got};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Golden {cout,s} for the incoming opcode and operands
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gold         = 9'h000;
    gold_illegal = 1'b0;
    case (txn.op)
      OP_ADD:  gold = {1'b0, txn.a} + {1'b0, txn.b};
      OP_SUB:  gold = {(txn.a < txn.b), 8'(txn.a - txn.b)};
      OP_AND:  gold = {1'b0, txn.a & txn.b};
      OP_OR:   gold = {1'b0, txn.a | txn.b};
      OP_XOR:  gold = {1'b0, txn.a ^ txn.b};
      OP_XNOR: gold = {1'b0, ~(txn.a ^ txn.b)};
      OP_SHL:  gold = {txn.a[7], txn.a[6:0], 1'b0};
      OP_SHR:  gold = {txn.a[0], 1'b0, txn.a[7:1]};
      OP_ROL:  gold = {txn.a[7], txn.a[6:0], txn.a[7]};
      OP_ROR:  gold = {txn.a[0], txn.a[0], txn.a[7:1]};
      OP_NOT:  gold = {1'b0, ~txn.a};
      OP_INC:  gold = {1'b0, txn.a} + 9'd1;
      default: gold_illegal = 1'b1;
    endcase
  end

  // Stage-1 payload capture on every accepted transfer
  // NOTE: payload registers carry no reset; s1_valid alone qualifies them, so their reset value is never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op      <= txn.op;
      s1_a       <= txn.a;
      s1_b       <= txn.b;
      s1_exp     <= gold;
      s1_got     <= {txn.dut_cout, txn.dut_s};
      s1_illegal <= gold_illegal;
    end
  end

  // Control FSM, stage-1 valid and all stage-2 state (counters, capture, MISR)
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      ready_q     <= 1'b0;
      halted      <= 1'b0;
      s1_valid    <= 1'b0;
      checked_cnt <= '0;
      err_cnt     <= '0;
      illegal_cnt <= '0;
      fail        <= 1'b0;
      ff_op       <= '0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_exp      <= '0;
      ff_got      <= '0;
      signature   <= SIG_SEED;
    end else if (clear) begin
      // clear flushes the pipeline and wins over a same-cycle compare
      state       <= ST_RUN;
      ready_q     <= 1'b1;
      halted      <= 1'b0;
      s1_valid    <= 1'b0;
      checked_cnt <= '0;
      err_cnt     <= '0;
      illegal_cnt <= '0;
      fail        <= 1'b0;
      ff_op       <= '0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_exp      <= '0;
      ff_got      <= '0;
      signature   <= SIG_SEED;
    end else begin
      s1_valid <= accept;

      case (state)
        ST_RUN: begin
          ready_q <= 1'b1;
          halted  <= 1'b0;
          if (mismatch && STOP_ON_FAIL) begin
            state   <= ST_HALTED;
            ready_q <= 1'b0;
            halted  <= 1'b1;
          end
        end
        default: begin
          // Halted: anything still in stage 1 is dropped by cmp_en
          ready_q  <= 1'b0;
          halted   <= 1'b1;
          s1_valid <= 1'b0;
        end
      endcase

      if (cmp_en) begin
        checked_cnt <= sat_inc(checked_cnt);
        signature   <= sig_next;
        if (s1_illegal) illegal_cnt <= sat_inc(illegal_cnt);
        if (mismatch) begin
          err_cnt <= sat_inc(err_cnt);
          fail    <= 1'b1;
          if (!fail) begin
            ff_op  <= s1_op;
            ff_a   <= s1_a;
            ff_b   <= s1_b;
            ff_exp <= s1_exp;
            ff_got <= s1_got;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: directed vector table, hand-written
// multi-cycle sequences and a randomized stream scored against a
// behavioural model of the checker. Two instances: default parameters,
// and a 4-bit-counter variant that stops on the first failure.
module tb_alu_result_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  alu_result_checker_if if0 ();
  alu_result_checker_if if1 ();

  logic [15:0] chk0, err0, ill0;
  logic        fail0, halt0;
  logic [3:0]  ffop0;
  logic [7:0]  ffa0, ffb0;
  logic [8:0]  ffexp0, ffgot0;
  logic [15:0] sig0;

  logic [3:0]  chk1, err1, ill1;
  logic        fail1, halt1;
  logic [3:0]  ffop1;
  logic [7:0]  ffa1, ffb1;
  logic [8:0]  ffexp1, ffgot1;
  logic [15:0] sig1;

  alu_result_checker u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .txn(if0.slave),
    .checked_cnt(chk0), .err_cnt(err0), .illegal_cnt(ill0), .fail(fail0),
    .ff_op(ffop0), .ff_a(ffa0), .ff_b(ffb0), .ff_exp(ffexp0), .ff_got(ffgot0),
    .signature(sig0), .halted(halt0)
  );

  alu_result_checker #(.CNT_W(4), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .clear(clear), .txn(if1.slave),
    .checked_cnt(chk1), .err_cnt(err1), .illegal_cnt(ill1), .fail(fail1),
    .ff_op(ffop1), .ff_a(ffa1), .ff_b(ffb1), .ff_exp(ffexp1), .ff_got(ffgot1),
    .signature(sig1), .halted(halt1)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [8:0] golden(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int r;
    case (op)
      4'd1:  r = ai + bi;
      4'd2:  r = ((ai - bi) & 255) + ((ai < bi) ? 256 : 0);
      4'd3:  r = ai & bi;
      4'd4:  r = ai | bi;
      4'd6:  r = ai ^ bi;
      4'd7:  r = 255 - (ai ^ bi);
      4'd8:  r = ai * 2;
      4'd9:  r = (ai / 2) + (ai % 2) * 256;
      4'd10: r = ((ai * 2) % 256) + (ai / 128) + (ai / 128) * 256;
      4'd11: r = (ai / 2) + (ai % 2) * 128 + (ai % 2) * 256;
      4'd12: r = 255 - ai;
      4'd13: r = ai + 1;
      default: r = 0;
    endcase
    return 9'(r);
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd5) || (op == 4'd14) || (op == 4'd15);
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] sig, input logic [8:0] obs);
    int s = int'(sig) * 2;
    if (s >= 65536) s = (s - 65536) ^ 32'h1021;
    s = s ^ int'(obs);
    return 16'(s);
  endfunction

  int          m_chk, m_err, m_ill;
  bit          m_fail;
  logic [3:0]  m_op;
  logic [7:0]  m_a, m_b;
  logic [8:0]  m_exp, m_got;
  logic [15:0] m_sig;

  task automatic model_reset();
    m_chk = 0; m_err = 0; m_ill = 0; m_fail = 0;
    m_op = '0; m_a = '0; m_b = '0; m_exp = '0; m_got = '0;
    m_sig = 16'hFFFF;
  endtask

  task automatic model_apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [8:0] obs);
    logic [8:0] e = golden(op, a, b);
    if (m_chk < 65535) m_chk++;
    if (is_illegal(op) && m_ill < 65535) m_ill++;
    if (e != obs) begin
      if (m_err < 65535) m_err++;
      if (!m_fail) begin
        m_op = op; m_a = a; m_b = b; m_exp = e; m_got = obs;
      end
      m_fail = 1;
    end
    m_sig = misr(m_sig, obs);
  endtask

  task automatic compare_model(input string tag);
    check({tag, " checked"}, 64'(chk0), 64'(m_chk));
    check({tag, " err"}, 64'(err0), 64'(m_err));
    check({tag, " illegal"}, 64'(ill0), 64'(m_ill));
    check({tag, " fail"}, 64'(fail0), 64'(m_fail));
    check({tag, " ff"}, {26'b0, ffop0, ffa0, ffb0, ffexp0, ffgot0},
          {26'b0, m_op, m_a, m_b, m_exp, m_got});
    check({tag, " signature"}, 64'(sig0), 64'(m_sig));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle valid pulse to instance sel; returns at #1 after the edge.
  task automatic send(input int sel, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [8:0] obs);
    if0.op = op; if0.a = a; if0.b = b; if0.dut_s = obs[7:0]; if0.dut_cout = obs[8];
    if1.op = op; if1.a = a; if1.b = b; if1.dut_s = obs[7:0]; if1.dut_cout = obs[8];
    if0.in_valid = (sel == 0);
    if1.in_valid = (sel == 1);
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] obs;
    logic [8:0] exp;
    bit         ill;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] frozen;
    vecs[0]  = '{4'b0001, 8'h32, 8'h32, 9'h064, 9'h064, 1'b0};
    vecs[1]  = '{4'b0001, 8'hCE, 8'hB5, 9'h183, 9'h183, 1'b0};
    vecs[2]  = '{4'b0010, 8'h32, 8'h4B, 9'h1E7, 9'h1E7, 1'b0};
    vecs[3]  = '{4'b1000, 8'hCD, 8'h00, 9'h09A, 9'h19A, 1'b0};
    vecs[4]  = '{4'b0011, 8'hF0, 8'h3C, 9'h000, 9'h030, 1'b0};
    vecs[5]  = '{4'b0100, 8'hF0, 8'h3C, 9'h0FC, 9'h0FC, 1'b0};
    vecs[6]  = '{4'b0110, 8'hF0, 8'h3C, 9'h000, 9'h0CC, 1'b0};
    vecs[7]  = '{4'b0111, 8'hF0, 8'h3C, 9'h000, 9'h033, 1'b0};
    vecs[8]  = '{4'b1001, 8'h81, 8'h00, 9'h000, 9'h140, 1'b0};
    vecs[9]  = '{4'b1010, 8'h81, 8'h00, 9'h000, 9'h103, 1'b0};
    vecs[10] = '{4'b1011, 8'h81, 8'h00, 9'h000, 9'h1C0, 1'b0};
    vecs[11] = '{4'b1100, 8'h5A, 8'h00, 9'h000, 9'h0A5, 1'b0};
    vecs[12] = '{4'b1101, 8'hFF, 8'h00, 9'h000, 9'h100, 1'b0};
    vecs[13] = '{4'b1101, 8'h7F, 8'h00, 9'h080, 9'h080, 1'b0};
    vecs[14] = '{4'b0101, 8'h55, 8'h00, 9'h000, 9'h000, 1'b1};
    vecs[15] = '{4'b0101, 8'h55, 8'h00, 9'h001, 9'h000, 1'b1};
    vecs[16] = '{4'b0000, 8'h12, 8'h34, 9'h000, 9'h000, 1'b1};
    vecs[17] = '{4'b1111, 8'h12, 8'h34, 9'h0FF, 9'h000, 1'b1};

    if0.in_valid = 0; if0.op = 0; if0.a = 0; if0.b = 0; if0.dut_s = 0; if0.dut_cout = 0;
    if1.in_valid = 0; if1.op = 0; if1.a = 0; if1.b = 0; if1.dut_s = 0; if1.dut_cout = 0;

    // ---- reset state ----
    idle(2);
    check("reset in_ready", 64'(if0.in_ready), 64'd0);
    check("reset counters", {16'b0, chk0, err0, ill0}, 64'd0);
    check("reset fail/halted", {62'b0, fail0, halt0}, 64'd0);
    check("reset ff", {26'b0, ffop0, ffa0, ffb0, ffexp0, ffgot0}, 64'd0);
    check("reset signature", 64'(sig0), 64'hFFFF);
    rst_n = 1'b1;
    idle(1);
    check("run in_ready", 64'(if0.in_ready), 64'd1);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 18; i++) begin
      bit e;
      e = (vecs[i].obs != vecs[i].exp);
      do_clear();
      send(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].obs);
      check($sformatf("vec%0d latency", i), 64'(chk0), 64'd0);
      idle(1);
      check($sformatf("vec%0d checked", i), 64'(chk0), 64'd1);
      check($sformatf("vec%0d err", i), 64'(err0), 64'(e));
      check($sformatf("vec%0d fail", i), 64'(fail0), 64'(e));
      check($sformatf("vec%0d illegal", i), 64'(ill0), 64'(vecs[i].ill));
      check($sformatf("vec%0d signature", i), 64'(sig0), 64'(misr(16'hFFFF, vecs[i].obs)));
      if (e) check($sformatf("vec%0d ff_exp/got", i), {46'b0, ffexp0, ffgot0},
                   {46'b0, vecs[i].exp, vecs[i].obs});
    end

    // ---- back-to-back, no stall ----
    do_clear();
    check("b2b ready0", 64'(if0.in_ready), 64'd1);
    send(0, 4'b0001, 8'hCE, 8'hB5, 9'h183);
    check("b2b ready1", 64'(if0.in_ready), 64'd1);
    send(0, 4'b0010, 8'h32, 8'h4B, 9'h1E7);
    idle(1);
    check("b2b checked", 64'(chk0), 64'd2);
    check("b2b err", 64'(err0), 64'd0);

    // ---- first-failure capture holds ----
    do_clear();
    send(0, 4'b1000, 8'hCD, 8'h11, 9'h09A);
    idle(1);
    check("ff err", 64'(err0), 64'd1);
    check("ff fail", 64'(fail0), 64'd1);
    check("ff capture", {26'b0, ffop0, ffa0, ffb0, ffexp0, ffgot0},
          {26'b0, 4'h8, 8'hCD, 8'h11, 9'h19A, 9'h09A});
    send(0, 4'b0011, 8'hFF, 8'h0F, 9'h1FF);
    idle(1);
    check("ff second err", 64'(err0), 64'd2);
    check("ff hold", {26'b0, ffop0, ffa0, ffb0, ffexp0, ffgot0},
          {26'b0, 4'h8, 8'hCD, 8'h11, 9'h19A, 9'h09A});

    // ---- clear priority over an in-flight compare ----
    do_clear();
    send(0, 4'b0001, 8'h01, 8'h01, 9'h003);
    clear = 1'b1;
    check("clear keeps ready", 64'(if0.in_ready), 64'd1);
    @(posedge clk); #1;
    clear = 1'b0;
    idle(2);
    check("clear flush counters", {16'b0, chk0, err0, ill0}, 64'd0);
    check("clear flush fail", 64'(fail0), 64'd0);
    check("clear flush signature", 64'(sig0), 64'hFFFF);

    // ---- randomized stream vs model ----
    do_clear();
    model_reset();
    for (int blk = 0; blk < 4; blk++) begin
      for (int n = 0; n < 60; n++) begin
        logic [3:0] op;
        logic [7:0] a, b;
        logic [8:0] obs;
        op  = 4'($urandom_range(15));
        a   = 8'($urandom);
        b   = 8'($urandom);
        obs = golden(op, a, b);
        if ($urandom_range(3) == 0) obs = 9'($urandom_range(511));
        send(0, op, a, b, obs);
        model_apply(op, a, b, obs);
        if ($urandom_range(7) == 0) idle(1);
      end
      idle(2);
      compare_model($sformatf("rand%0d", blk));
    end

    // ---- STOP_ON_FAIL: halt and freeze ----
    do_clear();
    send(1, 4'b0001, 8'h01, 8'h01, 9'h002);
    send(1, 4'b0001, 8'h01, 8'h01, 9'h003);
    send(1, 4'b0001, 8'h02, 8'h02, 9'h004);
    send(1, 4'b0001, 8'h03, 8'h03, 9'h006);
    send(1, 4'b0001, 8'h04, 8'h04, 9'h008);
    idle(2);
    check("halt halted", 64'(halt1), 64'd1);
    check("halt in_ready", 64'(if1.in_ready), 64'd0);
    check("halt checked", 64'(chk1), 64'd2);
    check("halt err", 64'(err1), 64'd1);
    frozen = 16'(chk1);
    send(1, 4'b0001, 8'h05, 8'h05, 9'h00A);
    idle(3);
    check("halt frozen", 64'(chk1), 64'(frozen));
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("unhalt halted", 64'(halt1), 64'd0);
    check("unhalt in_ready", 64'(if1.in_ready), 64'd1);
    check("unhalt counters", {52'b0, chk1, err1, ill1}, 64'd0);
    check("unhalt signature", 64'(sig1), 64'hFFFF);

    // ---- 4-bit counter saturation, then mismatch at saturation ----
    for (int n = 0; n < 20; n++) send(1, 4'b0001, 8'(n), 8'h10, 9'(n + 16));
    idle(1);
    check("sat checked", 64'(chk1), 64'd15);
    check("sat err", 64'(err1), 64'd0);
    send(1, 4'b1100, 8'h0F, 8'h00, 9'h000);
    idle(1);
    check("sat checked hold", 64'(chk1), 64'd15);
    check("sat mismatch err", 64'(err1), 64'd1);
    check("sat mismatch fail", 64'(fail1), 64'd1);
    check("sat mismatch ff", {46'b0, ffexp1, ffgot1}, {46'b0, 9'h0F0, 9'h000});

    // ---- reset while stage 1 is valid ----
    do_clear();
    send(0, 4'b0001, 8'h10, 8'h20, 9'h031);
    rst_n = 1'b0;
    #1;
    check("midreset in_ready", 64'(if0.in_ready), 64'd0);
    check("midreset counters", {16'b0, chk0, err0, ill0}, 64'd0);
    #2;
    rst_n = 1'b1;
    idle(3);
    check("postreset counters", {16'b0, chk0, err0, ill0}, 64'd0);
    check("postreset fail", 64'(fail0), 64'd0);
    check("postreset signature", 64'(sig0), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Synthesizable self-checking receiver for the 8-bit ALU's result stream. Accepts one transaction per cycle, each holding opcode, operands and the DUT's observed s/cout. Recomputes the golden result, compares it against the DUT result, and keeps pass/fail statistics, a first-failure capture and a 16-bit result signature. Sits after the ALU in the on-chip BIST path, alongside the stimulus source.

Parameters:
CNT_W, 16, width of the transaction and error counters (saturating).
STOP_ON_FAIL, 0, when 1 the checker halts on the first mismatch and stops accepting input.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of statistics, capture, signature and HALTED state.
in_valid  in  1  transaction valid.
in_ready  out  1  checker can accept; a transfer occurs when in_valid & in_ready.
op  in  4  ALU opcode C.
a  in  8  operand A.
b  in  8  operand B (ignored for unary ops).
dut_s  in  8  DUT result s.
dut_cout  in  1  DUT cout.
checked_cnt  out  CNT_W  compared transactions.
err_cnt  out  CNT_W  mismatching transactions.
illegal_cnt  out  CNT_W  transactions with an undefined opcode.
fail  out  1  sticky; set on the first mismatch.
ff_op / ff_a / ff_b  out  4/8/8  first-failure opcode and operands.
ff_exp / ff_got  out  9/9  first-failure {cout,s}, expected and observed.
signature  out  16  MISR over the DUT {cout,s}.
halted  out  1  FSM is in HALTED.

Behaviour:
- Reset (async, rst_n=0): all counters 0, fail 0, all ff_* 0, signature 16'hFFFF, FSM RUN, pipeline valids 0, in_ready 0 while in reset.
- Golden model, 9-bit {cout,s}:
  - 0001 ADD: a+b, cout = bit 8.
  - 0010 SUB: a-b mod 256, cout = borrow (a<b).
  - 0011 AND, 0100 OR, 0110 XOR, 0111 XNOR: cout = 0.
  - 1000 SHL: a<<1, cout = a[7].
  - 1001 SHR: a>>1, cout = a[0].
  - 1010 ROL, 1011 ROR: cout = the bit rotated through.
  - 1100 NOT: ~a, cout = 0.
  - 1101 INC: a+1, cout = carry.
  - Any other opcode: expected 9'h000, and illegal_cnt increments; the transaction is still compared.
- Pipeline:
  - Stage 1 registers the transaction and the expected result.
  - Stage 2 compares and updates counters, capture and signature.
  - A transfer in cycle t is visible on all outputs after edge t+2.
  - Throughput is 1 per cycle; no back-pressure in RUN.
- Counters saturate at all-ones and never wrap.
- MISR, per compared transaction: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {7'b0, dut_cout, dut_s}.
- FSM:
  - RUN: in_ready = 1. On a mismatch in stage 2 with STOP_ON_FAIL=1, go to HALTED.
  - HALTED: in_ready = 0, halted = 1. Transactions already in stage 1 are dropped and not counted. Only clear or reset returns to RUN.
- First failure: the ff_* registers load only when a mismatch occurs while fail = 0, then hold.
- clear:
  - Same reset values as rst_n, applied synchronously.
  - Has priority over a same-cycle compare.
  - Flushes both stages.
  - in_ready stays 1 during clear in RUN.
- A mismatch and saturation in the same cycle: fail and capture still update.
- Reset mid-pipeline discards in-flight transactions.

Test Plan:
- ADD a=0x32 b=0x32, dut {0,0x64} -> checked_cnt=1, err_cnt=0, fail=0 two cycles after transfer.
- ADD a=0xCE b=0xB5 with dut {1,0x83}, then SUB a=0x32 b=0x4B with dut {1,0xE7}, back-to-back -> checked_cnt=2, err_cnt=0, no stall.
- SHL a=0xCD with wrong dut {0,0x9A} -> err_cnt=1, fail=1, ff_op=8, ff_a=0xCD, ff_exp=9'h19A, ff_got=9'h09A. A later mismatch leaves ff_* unchanged.
- STOP_ON_FAIL=1, mismatch followed by 3 valid transfers -> halted=1, in_ready=0, checked_cnt frozen. clear -> halted=0, all counters 0, signature 16'hFFFF.
- op=0101 a=0x55 with dut {0,0x00} -> illegal_cnt=1, err_cnt=0. Same op with dut s=0x01 -> err_cnt=1.
- CNT_W=4, 20 passing transfers -> checked_cnt holds at 15. Assert rst_n low while stage 1 is valid -> all outputs at reset values immediately, no late update after release.
